// File: rtl/conv3x3_filter_pkg.sv
// Shared encodings and default geometry for the 3x3 convolution filter.
package conv_pkg;

  localparam int IMG_W_DEF = 98;
  localparam int IMG_H_DEF = 98;
  localparam int PIX_W_DEF = 8;
  localparam int IDX_W     = 7;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_GAUSS = 2'b01,
    MODE_SOBEL = 2'b10,
    MODE_LAPL  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/conv3x3_filter_abs_sat8.sv
// Magnitude of an 11-bit signed value, clamped to 0..255.
module abs_sat8 (
  input  logic signed [10:0] value,
  output logic        [7:0]  mag
);

  logic [10:0] abs_s;

  // Two's-complement magnitude, then clamp to the 8-bit range
  always_comb begin
    abs_s = 11'd0;
    mag   = 8'd0;
    if (value[10]) begin
      abs_s = 11'(~value) + 11'd1;
    end else begin
      abs_s = 11'(value);
    end
    if (abs_s > 11'd255) begin
      mag = 8'hFF;
    end else begin
      mag = abs_s[7:0];
    end
  end

endmodule

// File: rtl/conv3x3_filter.sv
// 3x3 window filter: pass / Gaussian / Sobel / Laplacian, three-stage pipeline
// with a global stall, per-frame mode latch and output pixel indexing.
module conv3x3_filter
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9*PIX_W-1:0] in_window,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pixel,
  output logic [IDX_W-1:0]   out_row,
  output logic [IDX_W-1:0]   out_col,
  output logic               frame_done
);

  state_e             state_r;
  mode_e              mode_r;
  logic [IDX_W-1:0]   row_r, col_r;
  logic               frame_done_r;
  logic               stall_s, accept_s, out_hs_s, last_pix_s;

  // Stage 1: captured window and the mode it will be filtered with
  logic               v1_r;
  logic [9*PIX_W-1:0] win1_r;
  mode_e              m1_r;
  // Stage 2: signed sums
  logic               v2_r;
  mode_e              m2_r;
  logic [11:0]        gsum2_r;
  logic signed [10:0] gx2_r, gy2_r, lap2_r;
  logic [PIX_W-1:0]   e2_r;
  // Stage 3: final pixel
  logic               out_valid_r;
  logic [PIX_W-1:0]   out_pixel_r;

  logic [PIX_W-1:0]   a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s, i_s;
  logic [11:0]        gsum_s;
  logic [10:0]        gx_pos_s, gx_neg_s, gy_pos_s, gy_neg_s, lap_pos_s, lap_neg_s;
  logic signed [10:0] gx_s, gy_s, lap_s;
  logic [7:0]         gx_mag_s, gy_mag_s, lap_mag_s;
  logic [8:0]         sobel_sum_s;
  logic [PIX_W-1:0]   pixel_s;

  assign stall_s    = out_valid_r & ~out_ready;
  assign in_ready   = ~rst & ~stall_s & (state_r != ST_DONE);
  assign accept_s   = in_valid & in_ready;
  assign out_hs_s   = out_valid_r & out_ready;
  assign last_pix_s = (row_r == IDX_W'(IMG_H - 1)) && (col_r == IDX_W'(IMG_W - 1));

  assign a_s = win1_r[8*PIX_W +: PIX_W];
  assign b_s = win1_r[7*PIX_W +: PIX_W];
  assign c_s = win1_r[6*PIX_W +: PIX_W];
  assign d_s = win1_r[5*PIX_W +: PIX_W];
  assign e_s = win1_r[4*PIX_W +: PIX_W];
  assign f_s = win1_r[3*PIX_W +: PIX_W];
  assign g_s = win1_r[2*PIX_W +: PIX_W];
  assign h_s = win1_r[1*PIX_W +: PIX_W];
  assign i_s = win1_r[0*PIX_W +: PIX_W];

  // Kernel sums from the captured window; differences fit 11-bit signed
  always_comb begin
    gsum_s    = 12'(a_s) + 12'({b_s, 1'b0}) + 12'(c_s)
              + 12'({d_s, 1'b0}) + 12'({e_s, 2'b00}) + 12'({f_s, 1'b0})
              + 12'(g_s) + 12'({h_s, 1'b0}) + 12'(i_s);
    gx_pos_s  = 11'(c_s) + 11'({f_s, 1'b0}) + 11'(i_s);
    gx_neg_s  = 11'(a_s) + 11'({d_s, 1'b0}) + 11'(g_s);
    gy_pos_s  = 11'(g_s) + 11'({h_s, 1'b0}) + 11'(i_s);
    gy_neg_s  = 11'(a_s) + 11'({b_s, 1'b0}) + 11'(c_s);
    lap_pos_s = 11'({e_s, 2'b00});
    lap_neg_s = 11'(b_s) + 11'(d_s) + 11'(f_s) + 11'(h_s);
    gx_s      = signed'(gx_pos_s - gx_neg_s);
    gy_s      = signed'(gy_pos_s - gy_neg_s);
    lap_s     = signed'(lap_pos_s - lap_neg_s);
  end

  abs_sat8 u_abs_gx  (.value(gx2_r),  .mag(gx_mag_s));
  abs_sat8 u_abs_gy  (.value(gy2_r),  .mag(gy_mag_s));
  abs_sat8 u_abs_lap (.value(lap2_r), .mag(lap_mag_s));

  // Final pixel select; Sobel magnitudes are each clamped so a 9-bit sum suffices
  always_comb begin
    sobel_sum_s = 9'(gx_mag_s) + 9'(gy_mag_s);
    pixel_s     = e2_r;
    case (m2_r)
      MODE_PASS:  pixel_s = e2_r;
      MODE_GAUSS: pixel_s = PIX_W'(gsum2_r[11:4]);
      MODE_SOBEL: begin
        if (sobel_sum_s[8]) begin
          pixel_s = PIX_W'(8'hFF);
        end else begin
          pixel_s = PIX_W'(sobel_sum_s[7:0]);
        end
      end
      MODE_LAPL:  pixel_s = PIX_W'(lap_mag_s);
      default:    pixel_s = e2_r;
    endcase
  end

  // Pipeline registers; every stage freezes while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r        <= 1'b0;
      win1_r      <= {(9*PIX_W){1'b0}};
      m1_r        <= MODE_PASS;
      v2_r        <= 1'b0;
      m2_r        <= MODE_PASS;
      gsum2_r     <= 12'd0;
      gx2_r       <= 11'sd0;
      gy2_r       <= 11'sd0;
      lap2_r      <= 11'sd0;
      e2_r        <= {PIX_W{1'b0}};
      out_valid_r <= 1'b0;
      out_pixel_r <= {PIX_W{1'b0}};
    end else if (!stall_s) begin
      v1_r <= accept_s;
      if (accept_s) begin
        win1_r <= in_window;
        m1_r   <= (state_r == ST_IDLE) ? mode_e'(mode) : mode_r;
      end
      v2_r <= v1_r;
      if (v1_r) begin
        m2_r    <= m1_r;
        gsum2_r <= gsum_s;
        gx2_r   <= gx_s;
        gy2_r   <= gy_s;
        lap2_r  <= lap_s;
        e2_r    <= e_s;
      end
      out_valid_r <= v2_r;
      if (v2_r) begin
        out_pixel_r <= pixel_s;
      end
    end
  end

  // Frame FSM, mode latch and row/col counters advanced on each output handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      mode_r       <= MODE_PASS;
      row_r        <= {IDX_W{1'b0}};
      col_r        <= {IDX_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (out_hs_s) begin
        if (col_r == IDX_W'(IMG_W - 1)) begin
          col_r <= {IDX_W{1'b0}};
          if (row_r == IDX_W'(IMG_H - 1)) begin
            row_r <= {IDX_W{1'b0}};
          end else begin
            row_r <= row_r + IDX_W'(1);
          end
        end else begin
          col_r <= col_r + IDX_W'(1);
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_RUN;
            mode_r  <= mode_e'(mode);
          end
        end
        ST_RUN: begin
          if (out_hs_s && last_pix_s) begin
            state_r      <= ST_DONE;
            frame_done_r <= 1'b1;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_r;
  assign out_pixel  = out_pixel_r;
  assign out_row    = row_r;
  assign out_col    = col_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Self-checking bench for conv3x3_filter: kernel vector table, backpressure,
// full random-stall frame and mid-frame reset, checked by a scoreboard.
module tb_conv3x3_filter;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_window;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pixel;
  logic [6:0]  out_row;
  logic [6:0]  out_col;
  logic        frame_done;

  conv3x3_filter dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  typedef struct {
    logic [1:0]  m;
    logic [71:0] w;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  typedef struct packed {
    logic [1:0]  m;
    logic [71:0] w;
  } sb_t;

  int   checks = 0;
  int   failures = 0;
  sb_t  sbq[$];
  int   exp_row = 0, exp_col = 0, hs_count = 0, fd_count = 0;
  int   last_row = 0, last_col = 0;
  bit   done_exp = 0, frame_started = 0, sb_en = 0;
  logic [1:0] frame_mode = 2'b00;
  int   ready_mode = 0;
  vec_t vecs[13];
  logic [71:0] w1, wr;
  int   base, fd_base;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] mk(input logic [7:0] a, b, c, d, e, f, g, h, i);
    return {a, b, c, d, e, f, g, h, i};
  endfunction

  function automatic logic [7:0] ref_pix(input logic [1:0] m, input logic [71:0] w);
    int p[9];
    int gx, gy, lp, r;
    for (int k = 0; k < 9; k++) p[k] = int'(w[(8-k)*8 +: 8]);
    case (m)
      2'b00: r = p[4];
      2'b01: r = (p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5] + p[6] + 2*p[7] + p[8]) / 16;
      2'b10: begin
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        r = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (r > 255) r = 255;
      end
      default: begin
        lp = 4*p[4] - (p[1] + p[3] + p[5] + p[7]);
        r = lp < 0 ? -lp : lp;
        if (r > 255) r = 255;
      end
    endcase
    return 8'(r);
  endfunction

  // out_ready generator, updated mid-cycle away from both clock edges
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard monitor: samples on the falling edge what the next rising edge hands off
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sbq.delete();
      exp_row = 0;
      exp_col = 0;
      frame_started = 0;
      done_exp = 0;
    end else if (sb_en) begin
      chk("frame_done", 32'(frame_done), 32'(done_exp));
      if (frame_done) fd_count++;
      done_exp = 0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          if (!frame_started) begin
            frame_mode = e.m;
            frame_started = 1;
          end
          chk("pixel", 32'(out_pixel), 32'(ref_pix(frame_mode, e.w)));
        end
        chk("row", 32'(out_row), 32'(exp_row));
        chk("col", 32'(out_col), 32'(exp_col));
        last_row = int'(out_row);
        last_col = int'(out_col);
        hs_count++;
        if (exp_col == 97) begin
          exp_col = 0;
          if (exp_row == 97) begin
            exp_row = 0;
            done_exp = 1;
            frame_started = 0;
          end else begin
            exp_row++;
          end
        end else begin
          exp_col++;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_out_pixel", 32'(out_pixel), 32'd0);
    chk("rst_out_row", 32'(out_row), 32'd0);
    chk("rst_out_col", 32'(out_col), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_win(input logic [71:0] w, input logic [1:0] m);
    int waited = 0;
    in_valid = 1'b1;
    in_window = w;
    mode = m;
    @(negedge clk);
    while (!in_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      sbq.push_back('{m: m, w: w});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (sbq.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_window = 72'd0;
    mode = 2'b00;
    out_ready = 1'b1;

    vecs[0]  = '{2'b10, mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80), 8'd0,   "sobel_flat80"};
    vecs[1]  = '{2'b01, mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80), 8'd128, "gauss_flat80"};
    vecs[2]  = '{2'b00, mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80), 8'd128, "pass_flat80"};
    vecs[3]  = '{2'b10, mk(8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF), 8'd255, "sobel_vedge"};
    vecs[4]  = '{2'b10, mk(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8'd255, "sobel_hedge"};
    vecs[5]  = '{2'b10, mk(8'h37, 8'h37, 8'h37, 8'h37, 8'h37, 8'h37, 8'h37, 8'h37, 8'h37), 8'd0,   "sobel_uniform"};
    vecs[6]  = '{2'b11, mk(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00), 8'd255, "lap_peak"};
    vecs[7]  = '{2'b11, mk(8'h00, 8'h0A, 8'h00, 8'h0A, 8'h00, 8'h0A, 8'h00, 8'h0A, 8'h00), 8'd40,  "lap_pit"};
    vecs[8]  = '{2'b11, mk(8'h00, 8'h0A, 8'h00, 8'h0A, 8'h0A, 8'h0A, 8'h00, 8'h0A, 8'h00), 8'd0,   "lap_flat"};
    vecs[9]  = '{2'b01, mk(8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00), 8'd1,   "gauss_trunc"};
    vecs[10] = '{2'b10, mk(8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8'd20,  "sobel_small"};
    vecs[11] = '{2'b00, mk(8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h77, 8'h88, 8'h99), 8'h5A, "pass_centre"};
    vecs[12] = '{2'b11, mk(8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00), 8'd255, "lap_neg_sat"};

    // Kernel table: one window per fresh frame, latency checked edge by edge
    for (int k = 0; k < 13; k++) begin
      do_reset();
      in_valid = 1'b1;
      in_window = vecs[k].w;
      mode = vecs[k].m;
      @(negedge clk);
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mode = ~vecs[k].m;
      @(negedge clk);
      chk("tbl_lat1", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("tbl_lat2", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("tbl_lat3_valid", 32'(out_valid), 32'd1);
      chk(vecs[k].name, 32'(out_pixel), 32'(vecs[k].exp));
      chk("tbl_row", 32'(out_row), 32'd0);
      chk("tbl_col", 32'(out_col), 32'd0);
      @(posedge clk);
      #1;
    end

    // Backpressure: three windows in flight behind a held-low out_ready
    do_reset();
    sb_en = 1;
    ready_mode = 2;
    w1 = mk(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90);
    drive_win(w1, 2'b01);
    drive_win(mk(8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF), 2'b10);
    drive_win(mk(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09), 2'b11);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_pixel_hold", 32'(out_pixel), 32'(ref_pix(2'b01, w1)));
      @(posedge clk);
    end
    #1;
    ready_mode = 0;
    wait_drain(50);

    // Full frame with random stalls, bubbles and ignored mid-frame mode changes
    do_reset();
    ready_mode = 1;
    base = hs_count;
    fd_base = fd_count;
    for (int n = 0; n < 9604; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      wr = 72'({$urandom(), $urandom(), $urandom()});
      drive_win(wr, (n == 0) ? 2'b10 : 2'($urandom_range(0, 3)));
    end
    wait_drain(2000);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_handoffs", 32'(hs_count - base), 32'd9604);
    chk("frame_done_pulses", 32'(fd_count - fd_base), 32'd1);
    chk("last_row", 32'(last_row), 32'd97);
    chk("last_col", 32'(last_col), 32'd97);
    ready_mode = 0;
    drive_win(mk(8'h40, 8'h80, 8'h40, 8'h80, 8'hFF, 8'h80, 8'h40, 8'h80, 8'h40), 2'b01);
    drive_win(mk(8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80), 2'b10);
    drive_win(mk(8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF), 2'b11);
    wait_drain(50);
    chk("next_frame_mode", 32'(dut.mode_r), 32'd1);

    // Reset in the middle of a frame after 50 output pixels
    do_reset();
    base = hs_count;
    for (int n = 0; n < 200; n++) begin
      if (hs_count - base >= 50) break;
      wr = 72'({$urandom(), $urandom(), $urandom()});
      drive_win(wr, 2'b10);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_mode", 32'(dut.mode_r), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_mode", 32'(dut.mode_r), 32'd0);
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    drive_win(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00), 2'b11);
    drive_win(mk(8'h00, 8'h0A, 8'h00, 8'h0A, 8'h00, 8'h0A, 8'h00, 8'h0A, 8'h00), 2'b00);
    wait_drain(50);
    chk("relatched_mode", 32'(dut.mode_r), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv3x3_filter.md
CONV3X3_FILTER -- requirements
Module: conv3x3_filter

Interface
REQ-001 SHALL have parameter IMG_W, 98, number of output columns per frame (window positions per row).
REQ-002 SHALL have parameter IMG_H, 98, number of output rows per frame.
REQ-003 SHALL have parameter PIX_W, 8, pixel width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mode  input  2  kernel select: 00 pass (centre), 01 Gaussian 1-2-1, 10 Sobel |Gx|+|Gy|, 11 Laplacian |4e-(b+d+f+h)|.
REQ-007 SHALL have port in_valid  input  1  in_window holds a valid 3x3 window.
REQ-008 SHALL have port in_ready  output  1  block accepts a window this cycle.
REQ-009 SHALL have port in_window  input  72  3x3 window, row-major; a=[71:64] top-left ... e=[39:32] centre ... i=[7:0] bottom-right.
REQ-010 SHALL have port out_valid  output  1  out_pixel/out_row/out_col valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the output this cycle.
REQ-012 SHALL have port out_pixel  output  8  filtered pixel.
REQ-013 SHALL have port out_row  output  7  output row index, 0..IMG_H-1.
REQ-014 SHALL have port out_col  output  7  output column index, 0..IMG_W-1.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is handed off.

Function
REQ-016 Input handshake: a window SHALL be accepted when in_valid && in_ready on a rising edge.
REQ-017 Output handshake: a pixel SHALL be transferred when out_valid && out_ready.
REQ-018 Pipeline SHALL have 3 stages: S1 capture/products, S2 signed sums, S3 abs/saturate/register; latency SHALL be 3 cycles from acceptance to out_valid with no stall.
REQ-019 Stall SHALL be defined as out_valid && !out_ready; during a stall all stages hold, in_ready=0, and out_pixel/out_row/out_col stay stable.
REQ-020 in_ready SHALL equal !stall && state!=DONE; accepting in_valid=0 inserts a bubble, no reorder and no loss.
REQ-021 FSM states SHALL be IDLE, RUN and DONE.
REQ-022 IDLE->RUN SHALL occur on the first accepted window, which latches mode for the whole frame; mode changes mid-frame SHALL be ignored.
REQ-023 RUN->DONE SHALL occur on the output handshake of pixel (IMG_H-1, IMG_W-1); DONE SHALL last one cycle with frame_done=1, then return to IDLE.
REQ-024 The col counter SHALL increment on each output handshake; at IMG_W-1 it SHALL wrap to 0 and increment row; at frame end both SHALL wrap to 0.
REQ-025 Gaussian SHALL be (a+2b+c+2d+4e+2f+g+2h+i)>>4 using a 12-bit unsigned sum, truncating, with no saturation needed.
REQ-026 Sobel SHALL use Gx=(c+2f+i)-(a+2d+g) and Gy=(g+2h+i)-(a+2b+c) as 11-bit signed values; output SHALL be min(|Gx|+|Gy|, 255).
REQ-027 Laplacian SHALL compute 4e-(b+d+f+h) as 11-bit signed; output SHALL be min(|value|, 255).
REQ-028 Pass mode SHALL output e unchanged.
REQ-029 Windows offered in DONE SHALL NOT be accepted (in_ready=0).

Reset
REQ-030 While rst=1, out_valid, frame_done, out_pixel, out_row and out_col SHALL be 0, in_ready SHALL be 0, and state SHALL be IDLE.
REQ-031 Reset mid-frame SHALL flush all pipeline valids and counters; the first pixel after reset SHALL be (row 0, col 0).
REQ-032 Latched mode SHALL reset to 00.

Structure
REQ-033 Package conv_pkg SHALL hold the mode encodings, FSM state encodings, and default IMG_W/IMG_H/PIX_W constants.
REQ-034 One combinational sub-module, abs_sat8, SHALL convert an 11-bit signed value to an 8-bit saturated magnitude, shared by Sobel and Laplacian.

Verification
REQ-035 Window of all 0x80: mode 10 gives 0, mode 01 gives 128, mode 00 gives 128, out_valid exactly 3 cycles after acceptance.
REQ-036 Sobel with columns a,d,g=0 and c,f,i=255: Gx=1020 -> 255; the same window rotated 90 degrees gives 255; a uniform window gives 0.
REQ-037 Laplacian: e=255 with others 0 -> 255; e=0 with b,d,f,h=10 -> 40; e=10 with b,d,f,h=10 -> 0.
REQ-038 Backpressure: 3 windows in flight, out_ready=0 for 5 cycles -> in_ready=0, out_pixel stable, then all 3 delivered in order.
REQ-039 Full frame of 9604 windows with random stalls: last pixel is (97,97), frame_done pulses once on the following cycle, and the next frame starts at (0,0) with newly latched mode.
REQ-040 rst asserted after 50 output pixels: out_valid=0 on the next cycle; the next frame's first pixel is (0,0) and mode reads 00 until re-latched.
